// File: rtl/tl_ul_reg_bridge_pkg.sv
// Shared TileLink-UL field widths, opcodes and FSM encoding for the MMIO register bridge.
package tl_ul_reg_bridge_pkg;

    localparam int TL_AW    = 32;
    localparam int TL_DW    = 32;
    localparam int TL_MW    = 4;
    localparam int TL_OPW   = 3;
    localparam int TL_PW    = 3;
    localparam int TL_SZW   = 3;
    localparam int TL_SRCW  = 8;
    localparam int TL_SINKW = 1;

    typedef enum logic [TL_OPW-1:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [TL_OPW-1:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // A request the register bus cannot legally carry is answered with denied=1.
    function automatic logic req_is_bad(input logic [TL_OPW-1:0] op,
                                        input logic [TL_SZW-1:0] size,
                                        input logic [1:0]        addr_lo,
                                        input logic              corrupt);
        logic is_put;
        logic is_get;
        logic misaligned;
        is_put     = (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
        is_get     = (op == A_GET);
        misaligned = ((size == 3'd1) && addr_lo[0]) ||
                     ((size == 3'd2) && (addr_lo != 2'b00));
        return !(is_put || is_get) || (size > 3'd2) || misaligned || (is_put && corrupt);
    endfunction

endpackage

// File: rtl/tl_ul_reg_bridge_if.sv
// TL-UL A/D channels plus the req/ack register bus; 'slave' is the bridge's view,
// 'master' is the view of the core and peripherals that surround it.
interface tl_ul_reg_bridge_if
    import tl_ul_reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
);
    logic [TL_OPW-1:0]   a_opcode;
    logic [TL_PW-1:0]    a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_SRCW-1:0]  a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_MW-1:0]    a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                a_corrupt;
    logic                a_valid;
    logic                a_ready;

    logic [TL_OPW-1:0]   d_opcode;
    logic [TL_PW-1:0]    d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_SRCW-1:0]  d_source;
    logic [TL_SINKW-1:0] d_sink;
    logic                d_denied;
    logic [TL_DW-1:0]    d_data;
    logic                d_corrupt;
    logic                d_valid;
    logic                d_ready;

    logic                  reg_req;
    logic                  reg_we;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [3:0]            reg_wmask;
    logic [31:0]           reg_wdata;
    logic                  reg_ack;
    logic [31:0]           reg_rdata;
    logic                  reg_err;

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready,
        output reg_req, reg_we, reg_addr, reg_wmask, reg_wdata,
        input  reg_ack, reg_rdata, reg_err
    );

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
        output d_ready,
        input  reg_req, reg_we, reg_addr, reg_wmask, reg_wdata,
        output reg_ack, reg_rdata, reg_err
    );
endinterface

// File: rtl/tl_ul_reg_bridge.sv
// TL-UL slave for the MMIO window: one A message becomes one req/ack register access.
// Define TL_UL_REG_BRIDGE_TIMEOUT_EN to add a watchdog that denies unanswered requests.
module tl_ul_reg_bridge
    import tl_ul_reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    tl_ul_reg_bridge_if.slave bus
);
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic [TL_OPW-1:0]     opcode_q;
    logic [TL_SZW-1:0]     size_q;
    logic [TL_SRCW-1:0]    source_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TL_MW-1:0]      mask_q;
    logic [TL_DW-1:0]      data_q;
    logic                  corrupt_q;
    logic [31:0]           rdata_q;
    logic                  denied_q;

    logic is_get;
    logic bad;
    logic timeout;

    assign is_get = (opcode_q == A_GET);
    assign bad    = req_is_bad(opcode_q, size_q, addr_q[1:0], corrupt_q);

`ifdef TL_UL_REG_BRIDGE_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Held at zero outside REQ, so every REQ entry starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  cnt_q <= '0;
        else if (state_q != ST_REQ) cnt_q <= '0;
        else                       cnt_q <= cnt_q + 1'b1;
    end

    assign timeout = (state_q == ST_REQ) && !bus.reg_ack && (cnt_q == TIMEOUT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_LAST;
    assign timeout        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.a_valid)                state_d = ST_CHECK;
            ST_CHECK: state_d = bad ? ST_RESP : ST_REQ;
            ST_REQ:   if (bus.reg_ack || timeout)     state_d = ST_RESP;
            ST_RESP:  if (bus.d_ready)                state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_q  <= '0;
            size_q    <= '0;
            source_q  <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            corrupt_q <= 1'b0;
            rdata_q   <= '0;
            denied_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (bus.a_valid) begin
                    opcode_q  <= bus.a_opcode;
                    size_q    <= bus.a_size;
                    source_q  <= bus.a_source;
                    addr_q    <= bus.a_address[ADDR_WIDTH-1:0];
                    mask_q    <= bus.a_mask;
                    data_q    <= bus.a_data;
                    corrupt_q <= bus.a_corrupt;
                    rdata_q   <= '0;
                    denied_q  <= 1'b0;
                end
                ST_CHECK: denied_q <= bad;
                ST_REQ: begin
                    if (bus.reg_ack) begin
                        rdata_q  <= bus.reg_rdata;
                        denied_q <= bus.reg_err;
                    end else if (timeout) begin
                        denied_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.a_ready = (state_q == ST_IDLE);

    assign bus.reg_req   = (state_q == ST_REQ);
    assign bus.reg_we    = (state_q == ST_REQ) && !is_get;
    assign bus.reg_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.reg_wmask = is_get ? 4'hF : mask_q;
    assign bus.reg_wdata = data_q;

    assign bus.d_valid   = (state_q == ST_RESP);
    assign bus.d_opcode  = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    assign bus.d_param   = '0;
    assign bus.d_size    = size_q;
    assign bus.d_source  = source_q;
    assign bus.d_sink    = '0;
    assign bus.d_denied  = denied_q;
    assign bus.d_data    = is_get ? rdata_q : '0;
    assign bus.d_corrupt = denied_q && is_get;

    logic unused_bits;
    assign unused_bits = ^{bus.a_param, bus.a_address[TL_AW-1:ADDR_WIDTH]};

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// Directed bench for tl_ul_reg_bridge; covers the watchdog when TL_UL_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_tl_ul_reg_bridge;
    import tl_ul_reg_bridge_pkg::*;

`ifdef TL_UL_REG_BRIDGE_TIMEOUT_EN
    localparam int TO_CYCLES = 4;
`else
    localparam int TO_CYCLES = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tl_ul_reg_bridge_if #(.ADDR_WIDTH(12)) bus ();

    tl_ul_reg_bridge #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic idle_inputs();
        bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0; bus.a_source = '0;
        bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0; bus.a_corrupt = 1'b0;
        bus.a_valid = 1'b0; bus.d_ready = 1'b0;
        bus.reg_ack = 1'b0; bus.reg_rdata = '0; bus.reg_err = 1'b0;
    endtask

    // Presents one A beat for exactly one cycle; returns at the negedge of the CHECK cycle.
    task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          input logic corrupt);
        @(negedge clk);
        n_tests++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL a_ready_idle: got %b want 1", bus.a_ready); end
        bus.a_opcode = op; bus.a_size = size; bus.a_source = src; bus.a_address = addr;
        bus.a_mask = mask; bus.a_data = data; bus.a_corrupt = corrupt; bus.a_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0;
    endtask

    task automatic finish_d();
        bus.d_ready = 1'b1;
        @(negedge clk);
        bus.d_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (bus.a_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_a_ready: got %b want 1", bus.a_ready); end
        n_tests++; if (bus.d_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_d_valid: got %b want 0", bus.d_valid); end
        n_tests++; if (bus.reg_req !== 1'b0)  begin n_fail++; $display("FAIL rst_reg_req: got %b want 0", bus.reg_req); end
        n_tests++; if (bus.reg_we !== 1'b0)   begin n_fail++; $display("FAIL rst_reg_we: got %b want 0", bus.reg_we); end
        n_tests++; if (bus.reg_addr !== 12'h0) begin n_fail++; $display("FAIL rst_reg_addr: got %h want 000", bus.reg_addr); end
        n_tests++; if (bus.d_data !== 32'h0)  begin n_fail++; $display("FAIL rst_d_data: got %h want 0", bus.d_data); end
        rst = 1'b1;
    endtask

    task automatic test_get();
        send_a(3'd4, 3'd2, 8'd3, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
        n_tests++; if (bus.reg_req !== 1'b0) begin n_fail++; $display("FAIL get_check_no_req: got %b want 0", bus.reg_req); end
        @(negedge clk);
        n_tests++; if (bus.reg_req !== 1'b1)    begin n_fail++; $display("FAIL get_req: got %b want 1", bus.reg_req); end
        n_tests++; if (bus.reg_we !== 1'b0)     begin n_fail++; $display("FAIL get_we: got %b want 0", bus.reg_we); end
        n_tests++; if (bus.reg_addr !== 12'h010) begin n_fail++; $display("FAIL get_addr: got %h want 010", bus.reg_addr); end
        n_tests++; if (bus.reg_wmask !== 4'hF)  begin n_fail++; $display("FAIL get_wmask: got %h want f", bus.reg_wmask); end
        n_tests++; if (bus.a_ready !== 1'b0)    begin n_fail++; $display("FAIL get_a_ready_busy: got %b want 0", bus.a_ready); end
        @(negedge clk);
        n_tests++; if (bus.reg_req !== 1'b1)    begin n_fail++; $display("FAIL get_req_held: got %b want 1", bus.reg_req); end
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.reg_ack = 1'b0; bus.reg_rdata = '0;
        n_tests++; if (bus.d_valid !== 1'b1)        begin n_fail++; $display("FAIL get_d_valid: got %b want 1", bus.d_valid); end
        n_tests++; if (bus.reg_req !== 1'b0)        begin n_fail++; $display("FAIL get_req_dropped: got %b want 0", bus.reg_req); end
        n_tests++; if (bus.d_opcode !== 3'd1)       begin n_fail++; $display("FAIL get_d_opcode: got %0d want 1", bus.d_opcode); end
        n_tests++; if (bus.d_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL get_d_data: got %h want deadbeef", bus.d_data); end
        n_tests++; if (bus.d_source !== 8'd3)       begin n_fail++; $display("FAIL get_d_source: got %0d want 3", bus.d_source); end
        n_tests++; if (bus.d_size !== 3'd2)         begin n_fail++; $display("FAIL get_d_size: got %0d want 2", bus.d_size); end
        n_tests++; if (bus.d_denied !== 1'b0)       begin n_fail++; $display("FAIL get_d_denied: got %b want 0", bus.d_denied); end
        n_tests++; if (bus.d_corrupt !== 1'b0)      begin n_fail++; $display("FAIL get_d_corrupt: got %b want 0", bus.d_corrupt); end
        finish_d();
        n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL get_d_done: got %b want 0", bus.d_valid); end
        n_tests++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL get_a_ready_after: got %b want 1", bus.a_ready); end
    endtask

    task automatic test_put_partial();
        send_a(3'd1, 3'd2, 8'd9, 32'h0000_0004, 4'b0011, 32'h1234_5678, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.reg_req !== 1'b1)          begin n_fail++; $display("FAIL put_req: got %b want 1", bus.reg_req); end
        n_tests++; if (bus.reg_we !== 1'b1)           begin n_fail++; $display("FAIL put_we: got %b want 1", bus.reg_we); end
        n_tests++; if (bus.reg_wmask !== 4'b0011)     begin n_fail++; $display("FAIL put_wmask: got %b want 0011", bus.reg_wmask); end
        n_tests++; if (bus.reg_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL put_wdata: got %h want 12345678", bus.reg_wdata); end
        n_tests++; if (bus.reg_addr !== 12'h004)      begin n_fail++; $display("FAIL put_addr: got %h want 004", bus.reg_addr); end
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.reg_ack = 1'b0; bus.reg_rdata = '0;
        n_tests++; if (bus.d_valid !== 1'b1)   begin n_fail++; $display("FAIL put_d_valid: got %b want 1", bus.d_valid); end
        n_tests++; if (bus.reg_req !== 1'b0)   begin n_fail++; $display("FAIL put_no_rereq: got %b want 0", bus.reg_req); end
        n_tests++; if (bus.d_opcode !== 3'd0)  begin n_fail++; $display("FAIL put_d_opcode: got %0d want 0", bus.d_opcode); end
        n_tests++; if (bus.d_data !== 32'h0)   begin n_fail++; $display("FAIL put_d_data: got %h want 0", bus.d_data); end
        n_tests++; if (bus.d_denied !== 1'b0)  begin n_fail++; $display("FAIL put_d_denied: got %b want 0", bus.d_denied); end
        n_tests++; if (bus.d_source !== 8'd9)  begin n_fail++; $display("FAIL put_d_source: got %0d want 9", bus.d_source); end
        finish_d();
    endtask

    // Each row: opcode, size, address, corrupt, expected d_opcode, expected d_corrupt.
    task automatic test_bad_requests();
        logic [2:0]  op   [4] = '{3'd4, 3'd6, 3'd4, 3'd0};
        logic [2:0]  sz   [4] = '{3'd3, 3'd2, 3'd2, 3'd2};
        logic [31:0] ad   [4] = '{32'h000, 32'h008, 32'h012, 32'h00C};
        logic        cr   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  e_op [4] = '{3'd1, 3'd0, 3'd1, 3'd0};
        logic        e_cr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bool_stray_ack: begin
            @(negedge clk);
            bus.reg_ack = 1'b1; bus.reg_rdata = 32'h5555_5555;
            @(negedge clk);
            bus.reg_ack = 1'b0; bus.reg_rdata = '0;
            n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL stray_ack_d_valid: got %b want 0", bus.d_valid); end
        end
        for (int i = 0; i < 4; i++) begin
            send_a(op[i], sz[i], 8'd7, ad[i], 4'hF, 32'hAAAA_AAAA, cr[i]);
            bus.reg_ack = 1'b1;
            n_tests++; if (bus.reg_req !== 1'b0) begin n_fail++; $display("FAIL bad%0d_check_req: got %b want 0", i, bus.reg_req); end
            @(negedge clk);
            bus.reg_ack = 1'b0;
            n_tests++; if (bus.reg_req !== 1'b0)    begin n_fail++; $display("FAIL bad%0d_no_req: got %b want 0", i, bus.reg_req); end
            n_tests++; if (bus.d_valid !== 1'b1)    begin n_fail++; $display("FAIL bad%0d_d_valid: got %b want 1", i, bus.d_valid); end
            n_tests++; if (bus.d_denied !== 1'b1)   begin n_fail++; $display("FAIL bad%0d_denied: got %b want 1", i, bus.d_denied); end
            n_tests++; if (bus.d_opcode !== e_op[i]) begin n_fail++; $display("FAIL bad%0d_d_opcode: got %0d want %0d", i, bus.d_opcode, e_op[i]); end
            n_tests++; if (bus.d_corrupt !== e_cr[i]) begin n_fail++; $display("FAIL bad%0d_corrupt: got %b want %b", i, bus.d_corrupt, e_cr[i]); end
            n_tests++; if (bus.d_data !== 32'h0)    begin n_fail++; $display("FAIL bad%0d_d_data: got %h want 0", i, bus.d_data); end
            finish_d();
        end
    endtask

    task automatic test_backpressure();
        send_a(3'd4, 3'd2, 8'd5, 32'h0000_0020, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'hA5A5_0001;
        @(negedge clk);
        bus.reg_ack = 1'b0; bus.reg_rdata = '0;
        bus.a_opcode = 3'd4; bus.a_address = 32'h0000_0040; bus.a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.d_valid !== 1'b1)        begin n_fail++; $display("FAIL bp%0d_d_valid: got %b want 1", i, bus.d_valid); end
            n_tests++; if (bus.d_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL bp%0d_d_data: got %h want a5a50001", i, bus.d_data); end
            n_tests++; if (bus.d_source !== 8'd5)       begin n_fail++; $display("FAIL bp%0d_d_source: got %0d want 5", i, bus.d_source); end
            n_tests++; if (bus.a_ready !== 1'b0)        begin n_fail++; $display("FAIL bp%0d_a_ready: got %b want 0", i, bus.a_ready); end
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        n_tests++; if (bus.d_valid !== 1'b1) begin n_fail++; $display("FAIL bp_still_pending: got %b want 1", bus.d_valid); end
        finish_d();
        n_tests++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL bp_a_ready_after: got %b want 1", bus.a_ready); end
        n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL bp_d_valid_after: got %b want 0", bus.d_valid); end
    endtask

    task automatic test_err();
        send_a(3'd0, 3'd2, 8'd2, 32'h0000_0008, 4'hF, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        bus.reg_ack = 1'b1; bus.reg_err = 1'b1;
        @(negedge clk);
        bus.reg_ack = 1'b0; bus.reg_err = 1'b0;
        n_tests++; if (bus.d_valid !== 1'b1)   begin n_fail++; $display("FAIL err_d_valid: got %b want 1", bus.d_valid); end
        n_tests++; if (bus.d_denied !== 1'b1)  begin n_fail++; $display("FAIL err_denied: got %b want 1", bus.d_denied); end
        n_tests++; if (bus.d_corrupt !== 1'b0) begin n_fail++; $display("FAIL err_corrupt: got %b want 0", bus.d_corrupt); end
        n_tests++; if (bus.d_opcode !== 3'd0)  begin n_fail++; $display("FAIL err_d_opcode: got %0d want 0", bus.d_opcode); end
        finish_d();
    endtask

    task automatic test_reset_mid();
        send_a(3'd4, 3'd2, 8'd1, 32'h0000_0030, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.reg_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b want 1", bus.reg_req); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (bus.reg_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_cleared: got %b want 0", bus.reg_req); end
        n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_d_valid: got %b want 0", bus.d_valid); end
        n_tests++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_a_ready: got %b want 1", bus.a_ready); end
        @(negedge clk);
        rst = 1'b1;
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'h0000_0011;
        @(negedge clk);
        bus.reg_ack = 1'b0; bus.reg_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL rmid%0d_no_resp: got %b want 0", i, bus.d_valid); end
            n_tests++; if (bus.reg_req !== 1'b0) begin n_fail++; $display("FAIL rmid%0d_no_req: got %b want 0", i, bus.reg_req); end
            @(negedge clk);
        end
    endtask

`ifdef TL_UL_REG_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        send_a(3'd4, 3'd2, 8'd4, 32'h0000_0050, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        while (bus.reg_req === 1'b1 && req_cycles < 20) begin
            req_cycles++;
            @(negedge clk);
        end
        n_tests++; if (req_cycles != 4)        begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        n_tests++; if (bus.d_valid !== 1'b1)   begin n_fail++; $display("FAIL to_d_valid: got %b want 1", bus.d_valid); end
        n_tests++; if (bus.d_denied !== 1'b1)  begin n_fail++; $display("FAIL to_denied: got %b want 1", bus.d_denied); end
        n_tests++; if (bus.d_corrupt !== 1'b1) begin n_fail++; $display("FAIL to_corrupt: got %b want 1", bus.d_corrupt); end
        n_tests++; if (bus.d_data !== 32'h0)   begin n_fail++; $display("FAIL to_d_data: got %h want 0", bus.d_data); end
        finish_d();
    endtask
`else
    task automatic test_long_wait();
        int req_cycles = 0;
        send_a(3'd4, 3'd2, 8'd4, 32'h0000_0050, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (bus.reg_req === 1'b1) req_cycles++;
            @(negedge clk);
        end
        n_tests++; if (req_cycles != 300)    begin n_fail++; $display("FAIL long_req_cycles: got %0d want 300", req_cycles); end
        n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL long_no_resp: got %b want 0", bus.d_valid); end
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'hCAFE_0000;
        @(negedge clk);
        bus.reg_ack = 1'b0; bus.reg_rdata = '0;
        n_tests++; if (bus.d_valid !== 1'b1)        begin n_fail++; $display("FAIL long_d_valid: got %b want 1", bus.d_valid); end
        n_tests++; if (bus.d_denied !== 1'b0)       begin n_fail++; $display("FAIL long_denied: got %b want 0", bus.d_denied); end
        n_tests++; if (bus.d_data !== 32'hCAFE_0000) begin n_fail++; $display("FAIL long_d_data: got %h want cafe0000", bus.d_data); end
        finish_d();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_get();
        test_put_partial();
        test_bad_requests();
        test_backpressure();
        test_err();
        test_reset_mid();
`ifdef TL_UL_REG_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_ul_reg_bridge.md
Name: tl_ul_reg_bridge

Overview:
- TileLink-UL slave that terminates the core's MMIO A/D channels, i.e. the bus interface unit's MMIO window offset 0x0000–0x0FFF.
- Converts each A message into one transaction on a simple req/ack register bus that feeds the MMIO peripherals.
- Returns AccessAck / AccessAckData on the D channel.
- Single outstanding transaction; 4-state FSM; optional watchdog timeout.

Parameters:
- ADDR_WIDTH, 12, register-bus address width; TL address bits above this are ignored.
- TIMEOUT_CYCLES, 255, cycles to wait for reg ack before a denied response (only with timeout feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- tlb_i_tl_a_opcode/param/size/source/address/mask/data/corrupt  in  `TL_A_WIDTH_* each  A-channel fields
- tlb_i_tl_a_valid  in  1  A valid
- tlb_o_tl_a_ready  out  1  A ready
- tlb_o_tl_d_opcode/param/size/source/sink/denied/data/corrupt  out  `TL_D_WIDTH_* each  D-channel fields
- tlb_o_tl_d_valid  out  1  D valid
- tlb_i_tl_d_ready  in  1  D ready
- tlb_o_reg_req  out  1  register-bus request, held until ack
- tlb_o_reg_we  out  1  write enable
- tlb_o_reg_addr  out  ADDR_WIDTH  byte address, word-aligned ([1:0]=0)
- tlb_o_reg_wmask  out  4  byte write mask
- tlb_o_reg_wdata  out  32  write data
- tlb_i_reg_ack  in  1  transaction complete, single cycle
- tlb_i_reg_rdata  in  32  read data, valid with ack
- tlb_i_reg_err  in  1  slave error, valid with ack

Behaviour:
- Reset (rst=0, async): FSM=IDLE; a_ready=1; d_valid=0; reg_req=0; reg_we=0; all captured fields and outputs 0.
- IDLE: a_ready=1. On a_valid && a_ready, capture opcode, size, source, address, mask, data and corrupt; go to CHECK. No combinational path from A to reg bus.
- CHECK (1 cycle, a_ready=0): request is bad if any of the following holds:
  - opcode not in {Get=4, PutFullData=0, PutPartialData=1}
  - size > 2
  - address misaligned for its size
  - corrupt=1 on a Put
  - Bad request → RESP with denied=1, reg bus untouched. Otherwise → REQ.
- REQ: reg_req=1; we=1 for Put. wmask = captured mask for Put, 4'hF for Get. addr = {address[ADDR_WIDTH-1:2],2'b00}. Outputs stable until ack. On ack, latch rdata and err; err sets denied=1; → RESP.
- RESP: d_valid=1.
  - d_opcode = AccessAckData(1) for Get, AccessAck(0) for Put.
  - d_param=0, d_size=captured size, d_source=captured source, d_sink=0.
  - d_data = latched rdata for Get, 0 for Put. d_corrupt = denied && Get.
  - Fields held until d_valid && d_ready; then → IDLE; a_ready=1 next cycle.
- Best-case latency: A accept → reg_req 2 cycles; 0-wait ack → d_valid 1 cycle later.
- ack outside REQ is ignored. reg_req never reasserts in the cycle after ack.
- A new A beat is never accepted while a response is pending (single outstanding).
- Reset mid-transaction: everything returns to the IDLE values immediately. No response is issued for the aborted request.

Optional Feature:
- Macro: TL_UL_REG_BRIDGE_TIMEOUT_EN.
- Defined: 8-bit-min counter cleared on entry to REQ, increments each REQ cycle.
  - Reaching TIMEOUT_CYCLES without ack → drop reg_req, RESP with denied=1, d_data=0, corrupt=1 on Get.
  - Ack in the same cycle as expiry wins (normal response).
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared package/defines extend bli201v32itl_tl_defines.vh with:
  - opcode constants: TL_A Get/PutFull/PutPartial; TL_D AccessAck/AccessAckData
  - FSM state encoding constants: IDLE, CHECK, REQ, RESP
- No sub-module required; the timeout counter stays inline.

Test Plan:
- Get addr 0x010, size 2, source 3; reg acks after 2 cycles with rdata 0xDEADBEEF → d_opcode=1, d_data=0xDEADBEEF, d_source=3, denied=0; reg_addr=0x010, wmask=4'hF.
- PutPartialData addr 0x004, mask 4'b0011, data 0x12345678; 0-wait ack → reg_we=1, wmask=0011; d_opcode=0, d_data=0, denied=0.
- Get size 3 or opcode 6 → no reg_req; d_valid with denied=1 two cycles after accept.
- Hold d_ready=0 for 5 cycles during RESP → d fields stable, a_ready=0 throughout; a_ready=1 the cycle after the handshake.
- Ack with err=1 on Put → denied=1. rst=0 asserted during REQ → reg_req=0 and d_valid=0 immediately, no response.
- With TIMEOUT_EN and TIMEOUT_CYCLES=4, Get never acked → reg_req drops after 4 cycles; d_valid with denied=1, corrupt=1.
